// File: rtl/hv_reg_bank_pkg.sv
// Shared types, addresses and the CRC-8 routine for the HV register bank.
package hv_reg_bank_pkg;

  localparam int CRC_AW = 7;
  localparam int CRC_DW = 8;

  typedef enum logic [1:0] {
    LK_LOCKED   = 2'd0,
    LK_KEY1     = 2'd1,
    LK_UNLOCKED = 2'd2
  } lock_state_e;

  localparam logic [CRC_AW-1:0] STATUS_ADDR = 7'h7E;
  localparam logic [CRC_AW-1:0] KEY_ADDR    = 7'h7F;
  localparam logic [7:0]        KEY1_VAL    = 8'h5A;
  localparam logic [7:0]        KEY2_VAL    = 8'hA5;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  // Registered read response
  typedef struct packed {
    logic [CRC_DW-1:0] data;
    logic [7:0]        crc;
  } rd_rsp_t;

  // CRC-8 over {addr, data}, MSB first, no reflection, no final XOR
  function automatic logic [7:0] crc8_calc(input logic [CRC_AW-1:0] addr,
                                           input logic [CRC_DW-1:0] data);
    logic [CRC_AW+CRC_DW-1:0] msg;
    logic [7:0]               crc;
    logic                     fb;
    msg = {addr, data};
    crc = CRC8_INIT;
    for (int i = CRC_AW + CRC_DW - 1; i >= 0; i--) begin
      fb  = crc[7] ^ msg[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
    return crc;
  endfunction

endpackage

// File: rtl/hv_reg_bank_crc8.sv
// Combinational CRC-8 generator over {addr, data}.
module hv_reg_bank_crc8
  import hv_reg_bank_pkg::*;
(
  input  logic [CRC_AW-1:0] i_addr,
  input  logic [CRC_DW-1:0] i_data,
  output logic [7:0]        o_crc
);

  assign o_crc = crc8_calc(i_addr, i_data);

endmodule

// File: rtl/hv_reg_bank.sv
// Register bank responder: CRC-checked writes, key-sequence lock on the
// protected range, fixed-latency reads with a generated CRC.
module hv_reg_bank
  import hv_reg_bank_pkg::*;
#(
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int REG_CRC_W = 8,
  parameter int REG_NUM   = 32,
  parameter int PROT_BASE = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_reg_ren,
  input  logic                      i_reg_wen,
  input  logic [REG_AW-1:0]         i_reg_addr,
  input  logic [REG_DW-1:0]         i_reg_wdata,
  input  logic [REG_CRC_W-1:0]      i_reg_wcrc,
  output logic                      o_reg_wack,
  output logic                      o_reg_rack,
  output logic [REG_DW-1:0]         o_reg_rdata,
  output logic [REG_CRC_W-1:0]      o_reg_rcrc,
  output logic [REG_NUM*REG_DW-1:0] o_reg_q,
  output logic                      o_unlocked
);

  localparam int                IDX_W  = $clog2(REG_NUM);
  localparam logic [REG_AW-1:0] NUM_A  = REG_AW'(REG_NUM);
  localparam logic [REG_AW-1:0] PROT_A = REG_AW'(PROT_BASE);

  logic [REG_NUM-1:0][REG_DW-1:0] regs;
  lock_state_e                    lock_q;
  logic                           crc_err_q, prot_err_q, range_err_q;
  logic                           rack_q;
  rd_rsp_t                        rsp_q;

  logic [REG_CRC_W-1:0] wcrc_calc, rcrc_calc;
  logic [REG_DW-1:0]    rd_mux;
  logic [IDX_W-1:0]     idx;
  logic is_data, is_status, is_key, is_prot;
  logic crc_ok, wr_ok, set_crc, set_range, set_prot, reg_we, key_we, stat_clr;

  hv_reg_bank_crc8 u_wcrc (.i_addr(i_reg_addr), .i_data(i_reg_wdata), .o_crc(wcrc_calc));
  hv_reg_bank_crc8 u_rcrc (.i_addr(i_reg_addr), .i_data(rd_mux),      .o_crc(rcrc_calc));

  // Address decode and write qualification; CRC failure takes priority
  assign idx       = i_reg_addr[IDX_W-1:0];
  assign is_data   = i_reg_addr < NUM_A;
  assign is_status = i_reg_addr == STATUS_ADDR;
  assign is_key    = i_reg_addr == KEY_ADDR;
  assign is_prot   = is_data && (i_reg_addr >= PROT_A);
  assign crc_ok    = wcrc_calc == i_reg_wcrc;
  assign wr_ok     = i_reg_wen && crc_ok;
  assign set_crc   = i_reg_wen && !crc_ok;
  assign set_range = wr_ok && !is_data && !is_status && !is_key;
  assign set_prot  = wr_ok && is_prot && !o_unlocked;
  assign reg_we    = wr_ok && is_data && !(is_prot && !o_unlocked);
  assign key_we    = wr_ok && is_key;
  assign stat_clr  = i_reg_ren && is_status;

  assign o_reg_wack  = i_reg_wen;
  assign o_reg_rack  = rack_q;
  assign o_reg_rdata = rsp_q.data;
  assign o_reg_rcrc  = rsp_q.crc;
  assign o_reg_q     = regs;
  assign o_unlocked  = (lock_q == LK_UNLOCKED);

  // Read data source for the current address, sampled before any write lands
  always_comb begin
    rd_mux = '0;
    if (is_data)        rd_mux = regs[idx];
    else if (is_status) rd_mux = REG_DW'({range_err_q, prot_err_q, crc_err_q});
    else if (is_key)    rd_mux = REG_DW'(o_unlocked);
  end

  // Data register file
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    regs      <= '0;
    else if (reg_we) regs[idx] <= i_reg_wdata;
  end

  // Sticky error flags; a set in the same cycle as a status read wins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crc_err_q   <= 1'b0;
      prot_err_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      crc_err_q   <= set_crc   || (crc_err_q   && !stat_clr);
      prot_err_q  <= set_prot  || (prot_err_q  && !stat_clr);
      range_err_q <= set_range || (range_err_q && !stat_clr);
    end
  end

  // Key-sequence lock FSM, stepped only by CRC-valid key writes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_q <= LK_LOCKED;
    end else if (key_we) begin
      case (lock_q)
        LK_LOCKED: lock_q <= (i_reg_wdata == KEY1_VAL) ? LK_KEY1     : LK_LOCKED;
        LK_KEY1:   lock_q <= (i_reg_wdata == KEY2_VAL) ? LK_UNLOCKED : LK_LOCKED;
        default:   lock_q <= LK_LOCKED;
      endcase
    end
  end

  // One-cycle read response; data/CRC captured in the request cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rack_q <= 1'b0;
      rsp_q  <= '0;
    end else begin
      rack_q <= i_reg_ren;
      if (i_reg_ren) rsp_q <= '{data: rd_mux, crc: rcrc_calc};
    end
  end

endmodule

// File: tb/tb_hv_reg_bank.sv
// Bench for hv_reg_bank: directed vector table, reset corner, random vs model.
module tb_hv_reg_bank;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_reg_ren, i_reg_wen;
  logic [6:0]   i_reg_addr;
  logic [7:0]   i_reg_wdata, i_reg_wcrc;
  logic         o_reg_wack, o_reg_rack, o_unlocked;
  logic [7:0]   o_reg_rdata, o_reg_rcrc;
  logic [255:0] o_reg_q;

  int checks = 0;
  int failures = 0;

  hv_reg_bank dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_reg_ren(i_reg_ren), .i_reg_wen(i_reg_wen),
    .i_reg_addr(i_reg_addr), .i_reg_wdata(i_reg_wdata), .i_reg_wcrc(i_reg_wcrc),
    .o_reg_wack(o_reg_wack), .o_reg_rack(o_reg_rack),
    .o_reg_rdata(o_reg_rdata), .o_reg_rcrc(o_reg_rcrc),
    .o_reg_q(o_reg_q), .o_unlocked(o_unlocked)
  );

  always #5 i_clk = ~i_clk;

  // Reference model state
  logic [7:0] m_regs [32];
  bit         m_crc, m_prot, m_rng;
  int         m_key;            // number of correct key bytes seen in sequence
  bit         exp_rack;
  logic [7:0] exp_rd, exp_rc;

  // CRC as polynomial remainder: (msg*x^8 + init*x^15) mod (x^8+x^2+x+1)
  function automatic logic [7:0] ref_crc(input logic [6:0] a, input logic [7:0] d);
    logic [22:0] v;
    v = {a, d, 8'h00} ^ {8'hFF, 15'h0};
    for (int i = 22; i >= 8; i--)
      if (v[i]) v = v ^ (23'h107 << (i - 8));
    return v[7:0];
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] model_q();
    logic [255:0] v;
    for (int k = 0; k < 32; k++) v[k*8 +: 8] = m_regs[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_regs[k] = 8'h00;
    m_crc = 0; m_prot = 0; m_rng = 0; m_key = 0; exp_rack = 0;
  endtask

  task automatic model_step(input bit ren, input bit wen, input logic [6:0] a,
                            input logic [7:0] d, input bit good);
    bit sc, sp, sr;
    exp_rack = ren;
    if (ren) begin
      if (a < 32)          exp_rd = m_regs[a[4:0]];
      else if (a == 7'h7E) exp_rd = {5'b0, m_rng, m_prot, m_crc};
      else if (a == 7'h7F) exp_rd = {7'b0, m_key == 2};
      else                 exp_rd = 8'h00;
      exp_rc = ref_crc(a, exp_rd);
    end
    sc = 0; sp = 0; sr = 0;
    if (wen) begin
      if (!good) sc = 1;
      else if (a < 32) begin
        if (a >= 16 && m_key != 2) sp = 1;
        else m_regs[a[4:0]] = d;
      end else if (a == 7'h7F) begin
        if (m_key == 0 && d == 8'h5A)      m_key = 1;
        else if (m_key == 1 && d == 8'hA5) m_key = 2;
        else                               m_key = 0;
      end else if (a != 7'h7E) sr = 1;
    end
    if (ren && a == 7'h7E) begin m_crc = 0; m_prot = 0; m_rng = 0; end
    m_crc |= sc; m_prot |= sp; m_rng |= sr;
  endtask

  // One request cycle, entered and left at posedge+1
  task automatic do_cycle(input bit ren, input bit wen, input logic [6:0] a,
                          input logic [7:0] d, input bit good);
    i_reg_ren = ren; i_reg_wen = wen; i_reg_addr = a; i_reg_wdata = d;
    i_reg_wcrc = good ? ref_crc(a, d) : ref_crc(a, d) ^ 8'h5C;
    #1;
    chk("wack", o_reg_wack, wen);
    model_step(ren, wen, a, d, good);
    @(posedge i_clk); #1;
    i_reg_ren = 0; i_reg_wen = 0;
    chk("rack", o_reg_rack, exp_rack);
    if (exp_rack) begin
      chk("rdata", o_reg_rdata, exp_rd);
      chk("rcrc", o_reg_rcrc, exp_rc);
    end
    chk("reg_q", o_reg_q, model_q());
    chk("unlocked", o_unlocked, m_key == 2);
  endtask

  typedef struct {
    bit         ren, wen;
    logic [6:0] addr;
    logic [7:0] wdata;
    bit         good;
    logic [7:0] exp_rd;
    bit         exp_unl;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit w, input logic [6:0] a, input logic [7:0] d,
                     input bit g, input logic [7:0] e, input bit u);
    vec_t v;
    v.ren = r; v.wen = w; v.addr = a; v.wdata = d; v.good = g; v.exp_rd = e; v.exp_unl = u;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 0; i_reg_ren = 0; i_reg_wen = 0;
    i_reg_addr = 0; i_reg_wdata = 0; i_reg_wcrc = 0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_rack", o_reg_rack, 0);
    chk("rst_rdata", o_reg_rdata, 0);
    chk("rst_rcrc", o_reg_rcrc, 0);
    chk("rst_q", o_reg_q, 0);
    chk("rst_unl", o_unlocked, 0);
    chk("rst_wack", o_reg_wack, 0);
    i_rst_n = 1;

    //  ren wen addr   wdata  good exp_rd unl
    add(1, 0, 7'h03, 8'h00, 1, 8'h00, 0);
    add(0, 1, 7'h03, 8'h3C, 1, 8'h00, 0);
    add(1, 0, 7'h03, 8'h00, 1, 8'h3C, 0);
    add(0, 1, 7'h05, 8'hAA, 0, 8'h00, 0);
    add(1, 0, 7'h05, 8'h00, 1, 8'h00, 0);
    add(1, 0, 7'h7E, 8'h00, 1, 8'h01, 0);
    add(1, 0, 7'h7E, 8'h00, 1, 8'h00, 0);
    add(0, 1, 7'h14, 8'h11, 1, 8'h00, 0);
    add(1, 0, 7'h7E, 8'h00, 1, 8'h02, 0);
    add(0, 1, 7'h7F, 8'h5A, 1, 8'h00, 0);
    add(0, 1, 7'h7F, 8'hA5, 1, 8'h00, 1);
    add(1, 0, 7'h7F, 8'h00, 1, 8'h01, 1);
    add(0, 1, 7'h14, 8'h77, 1, 8'h00, 1);
    add(1, 0, 7'h14, 8'h00, 1, 8'h77, 1);
    add(0, 1, 7'h7F, 8'h00, 1, 8'h00, 0);
    add(1, 0, 7'h7F, 8'h00, 1, 8'h00, 0);
    add(0, 1, 7'h7F, 8'h5A, 1, 8'h00, 0);
    add(0, 1, 7'h7F, 8'h11, 1, 8'h00, 0);
    add(0, 1, 7'h7F, 8'hA5, 1, 8'h00, 0);
    add(1, 0, 7'h7F, 8'h00, 1, 8'h00, 0);
    add(0, 1, 7'h40, 8'h12, 1, 8'h00, 0);
    add(1, 0, 7'h7E, 8'h00, 1, 8'h04, 0);
    add(1, 0, 7'h50, 8'h00, 1, 8'h00, 0);
    add(1, 0, 7'h7E, 8'h00, 1, 8'h00, 0);
    add(1, 1, 7'h03, 8'h99, 1, 8'h3C, 0);
    add(1, 0, 7'h03, 8'h00, 1, 8'h99, 0);

    foreach (tbl[i]) begin
      do_cycle(tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].good);
      if (tbl[i].ren) chk($sformatf("tbl%0d_rd", i), o_reg_rdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_unl", i), o_unlocked, tbl[i].exp_unl);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int r, s;
      bit ren, wen, good;
      logic [6:0] a;
      logic [7:0] d;
      r = $urandom_range(0, 9);
      ren = (r < 4) || (r == 9);
      wen = (r >= 4);
      s = $urandom_range(0, 9);
      if (s < 5)      a = 7'($urandom_range(0, 31));
      else if (s < 7) a = 7'h7E;
      else if (s < 9) a = 7'h7F;
      else            a = 7'($urandom);
      d = 8'($urandom);
      if (a == 7'h7F && $urandom_range(0, 9) < 7) d = ($urandom_range(0, 1) != 0) ? 8'h5A : 8'hA5;
      good = $urandom_range(0, 9) != 0;
      do_cycle(ren, wen, a, d, good);
    end

    // Unlock and dirty state, then reset in the cycle after a read request
    do_cycle(0, 1, 7'h7F, 8'h5A, 1);
    do_cycle(0, 1, 7'h7F, 8'hA5, 1);
    do_cycle(0, 1, 7'h03, 8'hC3, 1);
    chk("pre_rst_unl", o_unlocked, 1);
    i_reg_ren = 1; i_reg_addr = 7'h03;
    @(posedge i_clk); #1;
    i_reg_ren = 0;
    i_rst_n = 0;
    model_reset();
    #1;
    chk("midrd_rack", o_reg_rack, 0);
    chk("midrd_rdata", o_reg_rdata, 0);
    chk("midrd_rcrc", o_reg_rcrc, 0);
    chk("midrd_q", o_reg_q, 0);
    chk("midrd_unl", o_unlocked, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      chk("post_rst_rack", o_reg_rack, 0);
    end
    do_cycle(1, 0, 7'h03, 8'h00, 1);
    chk("post_rst_rd3", o_reg_rdata, 8'h00);
    do_cycle(1, 0, 7'h7E, 8'h00, 1);
    chk("post_rst_status", o_reg_rdata, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hv_reg_bank.md
# hv_reg_bank

Register-bank responder on the high-voltage die: sits on the far side of the register-access arbiter and serves its single read/write request port. It holds the configuration registers and checks the CRC on every write. It enforces a key-sequence write lock on the protected address range and returns read data with a generated CRC. Accesses are never stalled; every request is acknowledged at fixed latency.

## Interface
- REG_AW, 7: address width.
- REG_DW, 8: data width.
- REG_CRC_W, 8: CRC width.
- REG_NUM, 32: implemented data registers, addresses 0..REG_NUM-1.
- PROT_BASE, 16: addresses PROT_BASE..REG_NUM-1 are write-protected.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_reg_ren  in  1  read request, one-cycle pulse.
- i_reg_wen  in  1  write request, one-cycle pulse.
- i_reg_addr  in  REG_AW  access address, valid with ren/wen.
- i_reg_wdata  in  REG_DW  write data.
- i_reg_wcrc  in  REG_CRC_W  CRC over {addr, wdata} from initiator.
- o_reg_wack  out  1  write acknowledge.
- o_reg_rack  out  1  read acknowledge.
- o_reg_rdata  out  REG_DW  read data, valid with rack.
- o_reg_rcrc  out  REG_CRC_W  CRC over {read addr, rdata}, valid with rack.
- o_reg_q  out  REG_NUM*REG_DW  flattened register contents; register k at [k*REG_DW +: REG_DW].
- o_unlocked  out  1  protected range writable.

## Operation
- CRC: CRC-8, polynomial 0x07, init 0xFF, MSB-first over the 15-bit {addr, data} with addr first. No reflection, no final XOR.
- Write, when i_reg_wen=1:
  - Compute the CRC of {i_reg_addr, i_reg_wdata}.
  - Mismatch with i_reg_wcrc: drop the write and set sticky crc_err.
  - Address >= REG_NUM, other than STATUS_ADDR and KEY_ADDR: drop the write and set range_err.
  - Address in the protected range while locked: drop the write and set prot_err.
  - Otherwise the register updates on the next clock edge.
- o_reg_wack is asserted combinationally in the same cycle as i_reg_wen, whether the write is accepted or dropped.
- Read, when i_reg_ren=1: o_reg_rack=1 on the following cycle. o_reg_rdata and o_reg_rcrc are registered in the request cycle.
  - Data registers return their contents.
  - STATUS_ADDR (7'h7E) returns {5'b0, range_err, prot_err, crc_err}. This read clears all three flags; a flag being set in the same cycle wins over the clear.
  - KEY_ADDR (7'h7F) returns {7'b0, o_unlocked}.
  - Any other unimplemented address returns 0 with no error flag set.
- Lock FSM, advanced only by CRC-valid writes to KEY_ADDR. States LOCKED, KEY1, UNLOCKED; reset state LOCKED.
  - LOCKED: data 0x5A goes to KEY1; other data stays LOCKED.
  - KEY1: data 0xA5 goes to UNLOCKED; other data goes to LOCKED.
  - UNLOCKED: any data goes to LOCKED.
  - o_unlocked = (state==UNLOCKED).
- ren and wen in the same cycle (the arbiter does not issue this):
  - The write is performed.
  - The read returns the pre-write value and is still acknowledged.

## Timing
- Write latency: wack in cycle 0; o_reg_q reflects the new value from cycle 1.
- Read latency: rack, rdata and rcrc one cycle after ren, held for one cycle only.
- Back-to-back operations every cycle are supported. A read the cycle after a write to the same address returns the new value.
- Reset values:
  - All registers, o_reg_q and o_reg_rdata = 0.
  - o_reg_rcrc = 0.
  - o_reg_rack = 0 and o_unlocked = 0.
  - Error flags = 0; FSM = LOCKED.
  - o_reg_wack is combinational and reads 0 while i_reg_wen=0.
- Reset asserted mid-read: rack is suppressed and does not reappear after reset releases.

## Structure
- Package hv_reg_bank_pkg holds:
  - lock_state_e typedef.
  - STATUS_ADDR, KEY_ADDR, KEY1_VAL=8'h5A and KEY2_VAL=8'hA5.
  - CRC8_POLY, CRC8_INIT.
  - Automatic function crc8_calc(addr, data), shared with verification.
- One sub-module, hv_reg_bank_crc8: a combinational CRC generator. It is instantiated twice, once for the write check and once for the read CRC.

## Test plan
- Reset, then read addr 3 -> rack one cycle later, rdata=0x00, rcrc=crc8_calc(7'h03, 8'h00).
- Write addr 3 data 0x3C with correct CRC -> wack same cycle; o_reg_q[31:24]=0x3C next cycle; read-back returns 0x3C.
- Write addr 5 with wrong CRC -> wack asserted, register unchanged; STATUS read returns 0x01, and a second STATUS read returns 0x00.
- Write addr 20 while locked -> dropped, prot_err set. Key 0x5A then 0xA5 -> o_unlocked=1. Write addr 20 data 0x77 -> accepted. Key 0x00 -> locked again.
- Key 0x5A, then 0x11 -> LOCKED, and a following 0xA5 does not unlock. Write addr 0x40 -> STATUS returns 0x04.
- Assert i_rst_n low the cycle after ren -> no rack; all outputs at reset values.
